// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package : ps2_pkg
// Brief   : Receiver FSM state encoding and the PS/2 scan codes it interprets.
// Rev     : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] EXT     = 8'hE0;
  localparam logic [7:0] BRK     = 8'hF0;
  localparam logic [7:0] K8_UP   = 8'h75;
  localparam logic [7:0] K2_DOWN = 8'h72;

endpackage
`default_nettype wire

// File: rtl/ps2_filtro.sv
`default_nettype none
// ============================================================================
// Module : ps2_filtro
// Brief  : Synchronises and de-glitches ps2_clk; emits a one-cycle fall pulse.
// Rev    : 1.0
// ============================================================================
module ps2_filtro #(
  parameter int FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic level,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT + 1) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  // The level flips only after FILT consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
      level  <= 1'b1;
      r_cnt  <= '0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], ps2_clk};
      fall   <= 1'b0;
      if (r_sync[1] == level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT - 1)) begin
        level <= r_sync[1];
        r_cnt <= '0;
        fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_decoder
// Brief  : PS/2 frame receiver; strips E0/F0 prefixes and strobes make codes.
// Rev    : 1.0
// ============================================================================
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int N      = 8,
  parameter int FILT   = 4,
  parameter int TO_CYC = 200000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [N-1:0] key_code,
  output logic         en_codigo,
  output logic         extendido,
  output logic         err_trama
);

  localparam int TW = $clog2(TO_CYC + 1);
  localparam int BW = $clog2(N);

  ps2_state_t    r_state, w_next;
  logic [1:0]    r_data_sync;
  logic [N-1:0]  r_shift;
  logic [BW-1:0] r_bit_cnt;
  logic          r_par;
  logic [TW-1:0] r_timer;
  logic          r_ext, r_brk;
  logic          w_level, w_fall_raw;
  logic          w_fall, w_data, w_timeout, w_good;

  ps2_filtro #(.FILT(FILT)) u_filtro (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .level   (w_level),
    .fall    (w_fall_raw)
  );

  assign w_fall    = w_fall_raw & ~w_level;
  assign w_data    = r_data_sync[1];
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_timer == TW'(TO_CYC - 1));
  // Odd parity over data+parity, plus a high stop bit.
  assign w_good    = w_data & (^{r_shift, r_par});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_data) w_next = ST_DATA;
        ST_DATA:   if (r_bit_cnt == BW'(N - 1)) w_next = ST_PARITY;
        ST_PARITY: w_next = ST_STOP;
        ST_STOP:   w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_sync <= 2'b11;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_timer     <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      key_code    <= '0;
      en_codigo   <= 1'b0;
      extendido   <= 1'b0;
      err_trama   <= 1'b0;
    end else begin
      r_data_sync <= {r_data_sync[0], ps2_data};
      en_codigo   <= 1'b0;
      err_trama   <= 1'b0;
      if (w_fall || r_state == ST_IDLE) r_timer <= '0;
      else                              r_timer <= r_timer + 1'b1;

      if (w_fall) begin
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[N-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          ST_PARITY: r_par <= w_data;
          ST_STOP: begin
            if (!w_good) begin
              err_trama <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end else if (r_shift == N'(EXT)) begin
              r_ext <= 1'b1;
            end else if (r_shift == N'(BRK)) begin
              r_brk <= 1'b1;
            end else if (r_brk) begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
            end else begin
              key_code  <= r_shift;
              extendido <= r_ext;
              en_codigo <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (w_timeout) begin
        err_trama <= 1'b1;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
